// File: rtl/admm_ctrl_pkg.sv
// admm_ctrl_pkg: shared types for the ADMM iteration scheduler.
// Scheduler states, stage ids, handshake phases and helpers.
package admm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIMAL,
        S_SLACK,
        S_DUAL,
        S_RESID,
        S_FINISH,
        S_DRAIN
    } sched_state_e;

    typedef enum logic [1:0] {
        STG_PRIMAL,
        STG_SLACK,
        STG_DUAL,
        STG_RES
    } stage_e;

    typedef enum logic {
        PH_REQ,
        PH_REL
    } phase_e;

    localparam int NUM_STAGES = 4;
    localparam int CHK_WIDTH  = 8;

    function automatic stage_e stage_of(input sched_state_e s);
        case (s)
            S_SLACK: stage_of = STG_SLACK;
            S_DUAL:  stage_of = STG_DUAL;
            S_RESID: stage_of = STG_RES;
            default: stage_of = STG_PRIMAL;
        endcase
    endfunction

endpackage

// File: rtl/stage_handshake.sv
// stage_handshake: REQ/REL start/done sequencing plus watchdog
// for whichever iteration stage the scheduler currently owns.
module stage_handshake
    import admm_ctrl_pkg::*;
#(
    parameter int                    WDOG_WIDTH = 20,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = 20'hFFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic kill,
    input  logic done,
    output logic start,
    output logic complete,
    output logic timeout
);

    logic                  active;
    phase_e                phase;
    logic [WDOG_WIDTH-1:0] wdog;

    // Start is held through REQ; completion is done seen low in REL.
    always_comb begin
        start    = active && (phase == PH_REQ);
        complete = active && (phase == PH_REL) && !done;
        timeout  = active && !complete
                   && (wdog == WDOG_LIMIT - 1'b1);
    end

    // Phase tracking and watchdog count for the outstanding stage.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            active <= 1'b0;
            phase  <= PH_REQ;
            wdog   <= '0;
        end else if (go) begin
            active <= 1'b1;
            phase  <= PH_REQ;
            wdog   <= '0;
        end else if (active) begin
            if (complete || timeout) begin
                active <= 1'b0;
                phase  <= PH_REQ;
            end else begin
                wdog <= wdog + 1'b1;
                if ((phase == PH_REQ) && done) begin
                    phase <= PH_REL;
                end
            end
        end
    end

endmodule

// File: rtl/admm_iteration_scheduler.sv
// admm_iteration_scheduler: sequences primal, slack, dual and residual
// stages of one ADMM solve; owns iteration, bank select and termination.
module admm_iteration_scheduler
    import admm_ctrl_pkg::*;
#(
    parameter int                    ITER_WIDTH     = 16,
    parameter int                    CHECK_INTERVAL = 1,
    parameter int                    WDOG_WIDTH     = 20,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT     = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  solve_start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] max_iter,
    output logic                  primal_start,
    input  logic                  primal_done,
    output logic                  slack_start,
    input  logic                  slack_done,
    output logic                  dual_start,
    input  logic                  dual_done,
    output logic                  res_start,
    input  logic                  res_done,
    input  logic                  res_converged,
    output logic                  z_bank_sel,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  solve_done,
    output logic                  converged,
    output logic                  timed_out,
    output logic                  stage_error
);

    localparam logic [CHK_WIDTH-1:0] CHK_LAST =
        CHK_WIDTH'(CHECK_INTERVAL - 1);

    sched_state_e          state;
    sched_state_e          state_n;
    logic [ITER_WIDTH-1:0] max_q;
    logic [ITER_WIDTH-1:0] iter_next;
    logic [CHK_WIDTH-1:0]  chk_cnt;
    logic                  res_conv_q;
    logic [NUM_STAGES-1:0] done_vec;
    stage_e                cur_stg;
    logic                  hs_done;
    logic                  hs_go;
    logic                  hs_kill;
    logic                  hs_start;
    logic                  hs_complete;
    logic                  hs_timeout;
    logic                  accept;
    logic                  iter_inc;
    logic                  set_conv;
    logic                  set_to;
    logic                  set_err;
    logic                  cap_res;
    logic                  check_due;

    // Route the done input of the owning stage to the shared handshake.
    always_comb begin
        done_vec = {res_done, dual_done, slack_done, primal_done};
        cur_stg  = stage_of(state);
        hs_done  = done_vec[cur_stg];
    end

    stage_handshake #(
        .WDOG_WIDTH (WDOG_WIDTH),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_hs (
        .clk      (clk),
        .rst      (rst),
        .go       (hs_go),
        .kill     (hs_kill),
        .done     (hs_done),
        .start    (hs_start),
        .complete (hs_complete),
        .timeout  (hs_timeout)
    );

    // Demultiplex the shared start onto the stage that owns it.
    always_comb begin
        primal_start = hs_start && (state == S_PRIMAL);
        slack_start  = hs_start && (state == S_SLACK);
        dual_start   = hs_start && (state == S_DUAL);
        res_start    = hs_start && (state == S_RESID);
        busy         = (state != S_IDLE);
        solve_done   = (state == S_FINISH);
    end

    // Next state and control strobes; abort beats timeout beats completion.
    always_comb begin
        state_n   = state;
        hs_go     = 1'b0;
        hs_kill   = 1'b0;
        accept    = 1'b0;
        iter_inc  = 1'b0;
        set_conv  = 1'b0;
        set_to    = 1'b0;
        set_err   = 1'b0;
        iter_next = iter_count + 1'b1;
        check_due = (chk_cnt == CHK_LAST) || (iter_next == max_q);
        cap_res   = (state == S_RESID) && hs_start && hs_done;
        case (state)
            S_IDLE: begin
                if (solve_start) begin
                    accept = 1'b1;
                    if (max_iter == '0) begin
                        set_to  = 1'b1;
                        state_n = S_FINISH;
                    end else begin
                        hs_go   = 1'b1;
                        state_n = S_PRIMAL;
                    end
                end
            end
            S_PRIMAL, S_SLACK, S_DUAL, S_RESID: begin
                if (abort) begin
                    hs_kill = 1'b1;
                    state_n = S_DRAIN;
                end else if (hs_timeout) begin
                    set_err = 1'b1;
                    state_n = S_DRAIN;
                end else if (hs_complete) begin
                    hs_go = 1'b1;
                    case (state)
                        S_PRIMAL: state_n = S_SLACK;
                        S_SLACK:  state_n = S_DUAL;
                        S_DUAL: begin
                            iter_inc = (iter_count != max_q);
                            state_n  = check_due ? S_RESID : S_PRIMAL;
                        end
                        default: begin
                            if (res_conv_q) begin
                                hs_go    = 1'b0;
                                set_conv = 1'b1;
                                state_n  = S_FINISH;
                            end else if (iter_count == max_q) begin
                                hs_go   = 1'b0;
                                set_to  = 1'b1;
                                state_n = S_FINISH;
                            end else begin
                                state_n = S_PRIMAL;
                            end
                        end
                    endcase
                end
            end
            S_FINISH: begin
                if (!solve_start) begin
                    state_n = S_IDLE;
                end
            end
            S_DRAIN: begin
                if ((done_vec == '0) && !solve_start) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register plus iteration, cadence and result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            max_q       <= '0;
            iter_count  <= '0;
            z_bank_sel  <= 1'b0;
            chk_cnt     <= '0;
            res_conv_q  <= 1'b0;
            converged   <= 1'b0;
            timed_out   <= 1'b0;
            stage_error <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                max_q       <= max_iter;
                iter_count  <= '0;
                chk_cnt     <= '0;
                converged   <= 1'b0;
                timed_out   <= 1'b0;
                stage_error <= 1'b0;
            end
            if (iter_inc) begin
                iter_count <= iter_next;
                z_bank_sel <= ~z_bank_sel;
                chk_cnt    <= (chk_cnt == CHK_LAST) ? '0 : chk_cnt + 1'b1;
            end
            if (hs_go || accept) begin
                res_conv_q <= 1'b0;
            end else if (cap_res) begin
                res_conv_q <= res_converged;
            end
            if (set_conv) begin
                converged <= 1'b1;
            end
            if (set_to) begin
                timed_out <= 1'b1;
            end
            if (set_err) begin
                stage_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_admm_iteration_scheduler.sv
// tb_admm_iteration_scheduler: directed checks of the ADMM scheduler
// using two instances (CHECK_INTERVAL 1 and 2, watchdog limit 16).
module tb_admm_iteration_scheduler;

    typedef struct {
        int    inst;
        int    mx;
        int    cv;
        int    exp_conv;
        int    exp_to;
        int    exp_iter;
        int    exp_z;
        string exp_seq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  solve_start = '0;
    logic [1:0]  abort = '0;
    logic [15:0] max_iter [2] = '{16'd0, 16'd0};
    logic [3:0]  hold [2] = '{4'd0, 4'd0};
    int          conv_iter [2] = '{0, 0};
    logic [3:0]  done_v [2] = '{4'd0, 4'd0};
    logic [1:0]  res_conv = '0;
    logic [1:0]  p_st, s_st, d_st, r_st;
    logic [1:0]  z_sel, busy, solve_done, converged, timed_out, stage_error;
    logic [15:0] iter_count [2];

    int          checks = 0;
    int          errors = 0;
    int          rcnt [2][4];
    string       seq_log [2];
    int          sd_cnt [2] = '{0, 0};
    int          overlap [2] = '{0, 0};
    logic [3:0]  prev_st [2] = '{4'd0, 4'd0};
    logic [3:0]  mon_st;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        admm_iteration_scheduler #(
            .ITER_WIDTH     (16),
            .CHECK_INTERVAL (g + 1),
            .WDOG_WIDTH     (20),
            .WDOG_LIMIT     (20'd16)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .solve_start   (solve_start[g]),
            .abort         (abort[g]),
            .max_iter      (max_iter[g]),
            .primal_start  (p_st[g]),
            .primal_done   (done_v[g][0]),
            .slack_start   (s_st[g]),
            .slack_done    (done_v[g][1]),
            .dual_start    (d_st[g]),
            .dual_done     (done_v[g][2]),
            .res_start     (r_st[g]),
            .res_done      (done_v[g][3]),
            .res_converged (res_conv[g]),
            .z_bank_sel    (z_sel[g]),
            .iter_count    (iter_count[g]),
            .busy          (busy[g]),
            .solve_done    (solve_done[g]),
            .converged     (converged[g]),
            .timed_out     (timed_out[g]),
            .stage_error   (stage_error[g])
        );
    end

    function automatic logic [3:0] starts(input int g);
        return {r_st[g], d_st[g], s_st[g], p_st[g]};
    endfunction

    function automatic logic [31:0] outs(input int g);
        return {6'd0, starts(g), busy[g], solve_done[g], z_sel[g],
                converged[g], timed_out[g], stage_error[g], iter_count[g]};
    endfunction

    function automatic vec_t mk(input int inst, input int mx, input int cv,
                                input int ec, input int et, input int ei,
                                input int ez, input string sq);
        vec_t v;
        v.inst = inst; v.mx = mx; v.cv = cv;
        v.exp_conv = ec; v.exp_to = et; v.exp_iter = ei;
        v.exp_z = ez; v.exp_seq = sq;
        return v;
    endfunction

    // Stage models (done 3 cycles after start) and start-order monitor.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mon_st = starts(g);
            if ($countones(mon_st) > 1) overlap[g]++;
            if (solve_done[g]) sd_cnt[g]++;
            for (int s = 0; s < 4; s++) begin
                if (mon_st[s] && !prev_st[g][s]) begin
                    case (s)
                        0: seq_log[g] = {seq_log[g], "P"};
                        1: seq_log[g] = {seq_log[g], "S"};
                        2: seq_log[g] = {seq_log[g], "D"};
                        default: seq_log[g] = {seq_log[g], "R"};
                    endcase
                end
                if (mon_st[s]) begin
                    rcnt[g][s]++;
                    if (rcnt[g][s] >= 3 && !hold[g][s]) begin
                        if (s == 3)
                            res_conv[g] = (conv_iter[g] != 0) &&
                                (int'(iter_count[g]) == conv_iter[g]);
                        done_v[g][s] = 1'b1;
                    end
                end else begin
                    rcnt[g][s] = 0;
                    done_v[g][s] = 1'b0;
                end
            end
            prev_st[g] = mon_st;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act,
                           input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int g, output int lat);
        lat = 0;
        while (solve_done[g] !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("solve_done_reached", solve_done[g], 1);
    endtask

    task automatic release_solve(input int g);
        solve_start[g] = 1'b0;
        @(posedge clk); #1;
        chk("release_to_idle", {busy[g], solve_done[g]}, 0);
    endtask

    initial begin
        vec_t  tbl [7];
        int    g, lat, n, wd, base, base_sd;
        string got;

        tbl[0] = mk(0, 5, 3, 1, 0, 3, 1, "PSDRPSDRPSDR");
        tbl[1] = mk(1, 4, 0, 0, 1, 4, 0, "PSDPSDRPSDPSDR");
        tbl[2] = mk(0, 0, 0, 0, 1, 0, 0, "");
        tbl[3] = mk(0, 2, 0, 0, 1, 2, 0, "PSDRPSDR");
        tbl[4] = mk(1, 3, 0, 0, 1, 3, 1, "PSDPSDRPSDR");
        tbl[5] = mk(1, 5, 2, 1, 0, 2, 0, "PSDPSDR");
        tbl[6] = mk(0, 2, 2, 1, 0, 2, 0, "PSDRPSDR");

        @(posedge clk); #1;
        chk("reset_outs_inst0", outs(0), 0);
        chk("reset_outs_inst1", outs(1), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            g = tbl[i].inst;
            do_reset();
            base = seq_log[g].len();
            max_iter[g]  = 16'(tbl[i].mx);
            conv_iter[g] = tbl[i].cv;
            solve_start[g] = 1'b1;
            wait_done(g, lat);
            if (tbl[i].mx == 0) chk("zero_iter_latency", lat, 1);
            chk("converged", converged[g], tbl[i].exp_conv);
            chk("timed_out", timed_out[g], tbl[i].exp_to);
            chk("iter_count", iter_count[g], tbl[i].exp_iter);
            chk("z_bank_sel", z_sel[g], tbl[i].exp_z);
            chk("busy_in_finish", busy[g], 1);
            got = seq_log[g].substr(base, seq_log[g].len() - 1);
            chk_str("start_order", got, tbl[i].exp_seq);
            release_solve(g);
        end

        do_reset();
        base_sd = sd_cnt[0];
        max_iter[0] = 16'd5;
        conv_iter[0] = 0;
        solve_start[0] = 1'b1;
        n = 0;
        while (!(iter_count[0] == 16'd1 && done_v[0][1]) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_window_found", n < 500, 1);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_slack_start_low", s_st[0], 0);
        chk("abort_all_starts_low", starts(0), 0);
        chk("abort_busy", busy[0], 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("drain_waits_solve_start", busy[0], 1);
        solve_start[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_exit_cycles", n, 1);
        chk("abort_iter_count", iter_count[0], 1);
        chk("abort_no_solve_done", sd_cnt[0] - base_sd, 0);

        do_reset();
        hold[0] = 4'b0100;
        max_iter[0] = 16'd5;
        conv_iter[0] = 0;
        solve_start[0] = 1'b1;
        wd = 0;
        n = 0;
        while (!stage_error[0] && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (d_st[0]) wd++;
        end
        chk("wdog_error_set", stage_error[0], 1);
        chk("wdog_dual_start_cycles", wd, 16);
        chk("wdog_starts_low", starts(0), 0);
        chk("wdog_no_solve_done", solve_done[0], 0);
        solve_start[0] = 1'b0;
        @(posedge clk); #1;
        chk("wdog_back_to_idle", busy[0], 0);
        chk("wdog_error_sticky", stage_error[0], 1);
        hold[0] = 4'b0000;
        conv_iter[0] = 1;
        solve_start[0] = 1'b1;
        @(posedge clk); #1;
        chk("wdog_error_cleared", stage_error[0], 0);
        wait_done(0, lat);
        chk("wdog_rerun_converged", converged[0], 1);
        chk("wdog_rerun_iter", iter_count[0], 1);
        release_solve(0);

        do_reset();
        max_iter[0] = 16'd5;
        conv_iter[0] = 0;
        solve_start[0] = 1'b1;
        n = 0;
        while (!(iter_count[0] == 16'd2 && s_st[0]) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_window_found", n < 1000, 1);
        rst = 1'b1;
        solve_start[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_midrun_outs_zero", outs(0), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        base = seq_log[0].len();
        max_iter[0] = 16'd2;
        solve_start[0] = 1'b1;
        wait_done(0, lat);
        chk("post_rst_timed_out", timed_out[0], 1);
        chk("post_rst_iter", iter_count[0], 2);
        got = seq_log[0].substr(base, seq_log[0].len() - 1);
        chk_str("post_rst_order", got, "PSDRPSDR");
        release_solve(0);

        chk("start_onehot_inst0", overlap[0], 0);
        chk("start_onehot_inst1", overlap[1], 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/admm_iteration_scheduler.md
Name: admm_iteration_scheduler

Overview:
- Top-level sequencer for one ADMM solve.
- Drives the four iteration stages in order through start/done handshakes: primal (LQR backward/forward pass), slack projection, dual update, and residual_calculator.
- Owns the iteration counter, the ping-pong select between the z and z_prev banks, the residual-check cadence, the per-stage watchdog and the solve-level termination (converged / max_iter / abort / error).

Parameters:
ITER_WIDTH, 16, width of max_iter and iter_count
CHECK_INTERVAL, 1, run the residual stage every CHECK_INTERVAL iterations; valid range 1..255
WDOG_WIDTH, 20, width of the per-stage watchdog counter
WDOG_LIMIT, 20'hFFFFF, cycles a stage may stay outstanding before stage_error is raised

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset; synchronous, active-high
solve_start  in  1  level request to start a solve; must stay high until solve_done
abort  in  1  cancel the solve in progress
max_iter  in  ITER_WIDTH  iteration limit; sampled when a solve is accepted
primal_start/primal_done  out/in  1/1  primal stage handshake
slack_start/slack_done  out/in  1/1  slack stage handshake
dual_start/dual_done  out/in  1/1  dual stage handshake
res_start/res_done  out/in  1/1  residual_calculator handshake
res_converged  in  1  residual_calculator converged flag; valid while res_done=1
z_bank_sel  out  1  selects which physical bank is z and which is z_prev; toggles once per completed iteration
iter_count  out  ITER_WIDTH  number of completed iterations
busy  out  1  high in every state except IDLE
solve_done  out  1  high in FINISH; held until solve_start falls
converged  out  1  valid while solve_done=1
timed_out  out  1  valid while solve_done=1; solve ended on max_iter
stage_error  out  1  sticky; set on watchdog expiry; cleared on the next accepted solve_start

Behaviour:
- Reset (synchronous on rst): state=IDLE; every output is 0, including z_bank_sel and iter_count.
- States: IDLE, PRIMAL, SLACK, DUAL, RESID, FINISH, DRAIN.
- Each stage state has two phases:
  - REQ: stage start=1 until its done=1 is sampled.
  - REL: start=0 until done=0 is sampled.
  - The next state is entered the cycle after done=0 is sampled.
  - Never more than one stage start is high at a time.
- IDLE + solve_start=1:
  - Latch max_iter; clear iter_count, converged, timed_out, stage_error.
  - If the latched max_iter=0: go to FINISH with timed_out=1, no stage started.
  - Otherwise go to PRIMAL; primal_start rises the cycle after acceptance.
- PRIMAL -> SLACK -> DUAL, each after its REL phase completes.
- On DUAL completion:
  - iter_count+1 and z_bank_sel toggles in the same cycle.
  - If (iter_count+1) mod CHECK_INTERVAL == 0, or iter_count+1 == max_iter: go to RESID.
  - Otherwise go to PRIMAL.
- In RESID:
  - res_converged is captured in the cycle res_done is first seen high.
  - After REL: if captured=1, go to FINISH with converged=1.
  - Else if iter_count == max_iter, go to FINISH with timed_out=1.
  - Else go to PRIMAL.
- If both converged and max_iter apply at the same time, converged=1 and timed_out=0.
- FINISH: solve_done=1 and busy=1; when solve_start=0 is sampled, go to IDLE with solve_done=0 the next cycle.
- Watchdog:
  - Counter clears on every stage entry and counts each cycle while in REQ or REL.
  - When it reaches WDOG_LIMIT: stage_error=1, all starts are driven to 0, and the block goes to DRAIN.
- abort=1 in any state except IDLE, FINISH or DRAIN: all starts=0 the next cycle, then go to DRAIN.
  - abort wins over a done arriving in the same cycle.
  - abort in IDLE or FINISH is ignored.
- DRAIN:
  - Wait until all four done inputs are 0 and solve_start=0, then go to IDLE.
  - solve_done is never asserted for an aborted or errored solve.
  - In DRAIN, iter_count is held and z_bank_sel is not toggled.
  - stage_error stays set until the next accepted solve_start.
- Counter width: iter_count saturates at the latched max_iter; no wrap-around is possible.

Decomposition:
- Package admm_ctrl_pkg:
  - sched_state_e enum.
  - stage_e enum {STG_PRIMAL, STG_SLACK, STG_DUAL, STG_RES}.
  - Phase enum {PH_REQ, PH_REL}.
  - Shared handshake width constants.
- One sub-module, stage_handshake:
  - Implements REQ/REL sequencing and the watchdog for a single requester.
  - Outputs: start, complete pulse, timeout pulse.
  - Instantiated once and muxed by stage_e.

Test Plan:
- max_iter=5, CHECK_INTERVAL=1; each stage done after 3 cycles; res_converged=1 on iteration 3 -> start order P,S,D,R repeated 3 times; solve_done with converged=1, timed_out=0, iter_count=3; z_bank_sel toggled 3 times (ends at 1).
- max_iter=4, CHECK_INTERVAL=2, res_converged=0 -> RESID entered after iterations 2 and 4 only; timed_out=1, iter_count=4, z_bank_sel=0.
- max_iter=0 -> solve_done one cycle after acceptance; timed_out=1; no stage start ever high.
- abort asserted on the same cycle as slack_done=1 in iteration 2 -> slack_start=0 next cycle; DRAIN until done inputs and solve_start are low; solve_done never high; iter_count=1.
- WDOG_LIMIT=16, dual_done held low -> stage_error=1 when the watchdog count reaches 16; dual_start=0 the next cycle; after solve_start falls, IDLE; stage_error cleared on the next accepted solve_start.
- rst pulsed while in SLACK of iteration 3 -> next cycle every output is 0 and state=IDLE; a fresh solve_start runs normally from iter_count=0.
